// File: rtl/gs_test_sequencer.sv
// gs_test_sequencer
// Runs one evoked-potential acquisition: R stimulus pulses, each followed by
// N captured ADC samples and G skipped gap samples, then flags eof to the
// host reader. Sits between the xillybus command/read streams, the sample
// source and the raw-signal FIFO.
//
// Handshakes:
//   Command port: a word is taken on a cycle where cmd_wren=1 and cmd_full=0.
//   Samples: sample_valid is a one-cycle strobe. There is no backpressure;
//   a strobe arriving while cap_full=1 during capture is lost and overrun is set.
//   FIFO port: cap_wren=1 for one cycle per written word. It is issued only
//   for strobes that saw cap_full=0.
module gs_test_sequencer #(
    parameter int STIM_CYCLES = 16
) (
    input  logic        bus_clk,
    input  logic        rst,
    input  logic        cmd_wren,
    input  logic [31:0] cmd_data,
    output logic        cmd_full,
    input  logic        rd_open,
    input  logic        sample_valid,
    input  logic [15:0] sample_data,
    output logic        stim_pulse,
    output logic        cap_wren,
    output logic [15:0] cap_data,
    input  logic        cap_full,
    output logic        eof,
    output logic        busy,
    output logic        overrun,
    output logic [2:0]  dbg_state
);

    localparam int SW = (STIM_CYCLES > 1) ? $clog2(STIM_CYCLES) : 1;
    localparam logic [SW-1:0] STIM_LAST = SW'(STIM_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STIM    = 3'd1,
        S_CAPTURE = 3'd2,
        S_GAP     = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [11:0]   r_n;
    logic [11:0]   r_g;
    logic [7:0]    r_r;
    logic [11:0]   r_cnt;
    logic [7:0]    r_rep;
    logic [SW-1:0] r_stim_cnt;
    logic          r_cap_wren;
    logic [15:0]   r_cap_data;
    logic          r_overrun;

    logic          w_cmd_ok;
    logic          w_accept;
    logic          w_write;
    logic          w_drop;
    logic          w_samp_last;
    logic          w_gap_last;
    logic          w_rep_last;

    // The command port is only open while idle.
    assign cmd_full    = (r_state != S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign eof         = (r_state == S_DONE);
    // Pulse follows the registered state but is cut the moment the reader closes.
    assign stim_pulse  = (r_state == S_STIM) && rd_open;
    assign cap_wren    = r_cap_wren;
    assign cap_data    = r_cap_data;
    assign overrun     = r_overrun;
    assign dbg_state   = r_state;

    assign w_cmd_ok    = cmd_wren && !cmd_full && rd_open &&
                         (cmd_data[11:0] != 12'd0) && (cmd_data[31:24] != 8'd0);
    assign w_samp_last = (r_cnt == (r_n - 12'd1));
    assign w_gap_last  = (r_cnt == (r_g - 12'd1));
    assign w_rep_last  = (r_rep == (r_r - 8'd1));

    // State register.
    always_ff @(posedge bus_clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus per-cycle capture decisions; reader close beats progress.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_write     = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_ok) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_STIM;
                end
            end
            S_STIM: begin
                if (!rd_open) begin
                    w_state_nxt = S_IDLE;
                end else if (r_stim_cnt == STIM_LAST) begin
                    w_state_nxt = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (!rd_open) begin
                    w_state_nxt = S_IDLE;
                end else if (sample_valid) begin
                    w_write = !cap_full;
                    w_drop  = cap_full;
                    if (w_samp_last) begin
                        if (w_rep_last) begin
                            w_state_nxt = S_DONE;
                        end else if (r_g == 12'd0) begin
                            w_state_nxt = S_STIM;
                        end else begin
                            w_state_nxt = S_GAP;
                        end
                    end
                end
            end
            S_GAP: begin
                if (!rd_open) begin
                    w_state_nxt = S_IDLE;
                end else if (sample_valid && w_gap_last) begin
                    w_state_nxt = S_STIM;
                end
            end
            S_DONE: begin
                if (!rd_open) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Run parameters, counters, FIFO write port and the sticky overrun flag.
    always_ff @(posedge bus_clk) begin
        if (rst) begin
            r_n        <= 12'd0;
            r_g        <= 12'd0;
            r_r        <= 8'd0;
            r_cnt      <= 12'd0;
            r_rep      <= 8'd0;
            r_stim_cnt <= '0;
            r_cap_wren <= 1'b0;
            r_cap_data <= 16'h0;
            r_overrun  <= 1'b0;
        end else begin
            r_cap_wren <= w_write;
            if (w_write) begin
                r_cap_data <= sample_data;
            end

            if (w_accept) begin
                r_n       <= cmd_data[11:0];
                r_g       <= cmd_data[23:12];
                r_r       <= cmd_data[31:24];
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end

            // Pulse length counter runs only while staying in STIM.
            if (r_state == S_STIM && w_state_nxt == S_STIM) begin
                r_stim_cnt <= r_stim_cnt + SW'(1);
            end else begin
                r_stim_cnt <= '0;
            end

            // One counter serves both the capture epoch and the gap; it restarts on every state change.
            if (w_state_nxt != r_state) begin
                r_cnt <= 12'd0;
            end else if (sample_valid && (r_state == S_CAPTURE || r_state == S_GAP)) begin
                r_cnt <= r_cnt + 12'd1;
            end

            // Completed repetitions; the last one exits to DONE without incrementing.
            if (w_accept) begin
                r_rep <= 8'd0;
            end else if (r_state == S_CAPTURE &&
                         (w_state_nxt == S_STIM || w_state_nxt == S_GAP)) begin
                r_rep <= r_rep + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_gs_test_sequencer.sv
// Bench for gs_test_sequencer: directed scenarios plus randomized runs,
// checked every cycle against a run-position model.
module tb_gs_test_sequencer;

  localparam int STIM = 16;

  logic        bus_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_wren = 1'b0;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_full;
  logic        rd_open = 1'b1;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        stim_pulse;
  logic        cap_wren;
  logic [15:0] cap_data;
  logic        cap_full;
  logic        eof;
  logic        busy;
  logic        overrun;
  logic [2:0]  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 bus_clk = ~bus_clk;

  gs_test_sequencer #(.STIM_CYCLES(STIM)) dut (
    .bus_clk      (bus_clk),
    .rst          (rst),
    .cmd_wren     (cmd_wren),
    .cmd_data     (cmd_data),
    .cmd_full     (cmd_full),
    .rd_open      (rd_open),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .stim_pulse   (stim_pulse),
    .cap_wren     (cap_wren),
    .cap_data     (cap_data),
    .cap_full     (cap_full),
    .eof          (eof),
    .busy         (busy),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A run is R repetitions of: STIM cycles of pulse, then a window of N+G
  // samples of which the first N go to the FIFO.
  bit          m_running = 0;
  bit          m_done = 0;
  bit          m_wren = 0;
  bit          m_overrun = 0;
  logic [15:0] m_data = 16'h0;
  int          m_pulse_left = 0;
  int          m_pos = 0;
  int          m_rep = 0;
  int          m_n = 0;
  int          m_g = 0;
  int          m_r = 0;

  always @(posedge bus_clk) begin
    m_wren = 1'b0;
    if (rst) begin
      m_running = 0; m_done = 0; m_pulse_left = 0; m_pos = 0; m_rep = 0;
      m_overrun = 0; m_data = 16'h0;
    end else if (!m_running && !m_done) begin
      if (cmd_wren && rd_open && cmd_data[11:0] != 0 && cmd_data[31:24] != 0) begin
        m_n = int'(cmd_data[11:0]);
        m_g = int'(cmd_data[23:12]);
        m_r = int'(cmd_data[31:24]);
        m_running = 1; m_pulse_left = STIM; m_pos = 0; m_rep = 0; m_overrun = 0;
      end
    end else if (m_done) begin
      if (!rd_open) m_done = 0;
    end else if (!rd_open) begin
      m_running = 0;
    end else if (m_pulse_left > 0) begin
      m_pulse_left--;
    end else if (sample_valid) begin
      if (m_pos < m_n) begin
        if (cap_full) m_overrun = 1;
        else begin m_wren = 1; m_data = sample_data; end
      end
      if (m_pos == m_n - 1 && m_rep == m_r - 1) begin
        m_running = 0; m_done = 1;
      end else if (m_pos == m_n + m_g - 1) begin
        m_pos = 0; m_rep++; m_pulse_left = STIM;
      end else begin
        m_pos++;
      end
    end
  end

  // ---------------- compare process (scoreboard) ----------------
  int wr_total = 0;
  int stim_total = 0;

  always @(negedge bus_clk) begin
    check("stim_pulse", stim_pulse, m_running && m_pulse_left > 0 && rd_open);
    check("cmd_full", cmd_full, m_running || m_done);
    check("busy", busy, m_running || m_done);
    check("eof", eof, m_done);
    check("cap_wren", cap_wren, m_wren);
    check("cap_data", cap_data, m_data);
    check("overrun", overrun, m_overrun);
    if (cap_wren === 1'b1) wr_total++;
    if (stim_pulse === 1'b1) stim_total++;
  end

  // ---------------- sample source ----------------
  int gen_mode = 0;    // 0 none, 1 periodic, 2 random
  int gen_period = 4;
  int full_mode = 0;   // 0 never full, 1 random, 2 full on 2nd sample of rep 0
  int gen_cnt = 0;

  initial begin
    sample_valid = 1'b0;
    sample_data = 16'h0;
    cap_full = 1'b0;
    forever begin
      @(posedge bus_clk); #3;
      gen_cnt++;
      case (gen_mode)
        1: sample_valid = (gen_cnt % gen_period == 0);
        2: sample_valid = ($urandom_range(0, 2) == 0);
        default: sample_valid = 1'b0;
      endcase
      sample_data = 16'($urandom_range(1, 65535));
      case (full_mode)
        1: cap_full = ($urandom_range(0, 3) == 0);
        2: cap_full = m_running && m_pulse_left == 0 && m_rep == 0 && m_pos == 1;
        default: cap_full = 1'b0;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge bus_clk); #3; end
  endtask

  task automatic send_cmd(input int n, input int g, input int r);
    cmd_data = {8'(r), 12'(g), 12'(n)};
    cmd_wren = 1'b1;
    tick(1);
    cmd_wren = 1'b0;
  endtask

  task automatic wait_eof(input string name, input int budget, input bit stray);
    int k = 0;
    while (eof !== 1'b1 && k < budget) begin
      if (stray && $urandom_range(0, 15) == 0) begin
        cmd_wren = 1'b1;
        cmd_data = $urandom;
      end else begin
        cmd_wren = 1'b0;
      end
      tick(1);
      k++;
    end
    cmd_wren = 1'b0;
    check({name, "_eof_reached"}, eof, 1'b1);
  endtask

  task automatic close_run();
    rd_open = 1'b0;
    tick(2);
    rd_open = 1'b1;
    tick(1);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int wb, sb, k;
    tick(3);
    check("reset_cmd_full", cmd_full, 1'b0);
    check("reset_cap_data", cap_data, 16'h0);
    rst = 1'b0;
    tick(2);

    // 1: N=4 G=2 R=2, sample every 4 clocks
    gen_mode = 1; gen_period = 4; full_mode = 0;
    wb = wr_total; sb = stim_total;
    send_cmd(4, 2, 2);
    wait_eof("t1", 400, 0);
    tick(1);
    check("t1_writes", wr_total - wb, 8);
    check("t1_stim_cycles", stim_total - sb, 32);
    close_run();

    // 2: rejected commands
    sb = stim_total;
    send_cmd(0, 2, 2); tick(3);
    check("t2_n0_busy", busy, 1'b0);
    send_cmd(4, 2, 0); tick(3);
    check("t2_r0_busy", busy, 1'b0);
    rd_open = 1'b0;
    send_cmd(4, 2, 2); tick(3);
    check("t2_closed_full", cmd_full, 1'b0);
    rd_open = 1'b1; tick(1);
    check("t2_stim_cycles", stim_total - sb, 0);

    // 3: FIFO full on the 2nd sample
    full_mode = 2;
    wb = wr_total;
    send_cmd(4, 2, 2);
    wait_eof("t3", 400, 0);
    tick(1);
    check("t3_writes", wr_total - wb, 7);
    check("t3_overrun", overrun, 1'b1);
    close_run();
    full_mode = 0;

    // 4: reader closes during capture of the first repetition
    wb = wr_total;
    send_cmd(4, 2, 2);
    k = 0;
    while (!(m_running && m_pulse_left == 0 && m_rep == 0 && m_pos == 2) && k < 500) begin
      tick(1); k++;
    end
    check("t4_reached_capture", k < 500, 1'b1);
    rd_open = 1'b0;
    tick(3);
    check("t4_writes", wr_total - wb, 2);
    check("t4_eof", eof, 1'b0);
    check("t4_cmd_full", cmd_full, 1'b0);
    rd_open = 1'b1; tick(1);

    // 4b: reader closes mid-pulse; pulse must drop within the same cycle
    send_cmd(4, 2, 2);
    tick(5);
    rd_open = 1'b0;
    #1;
    check("t4b_stim_gate", stim_pulse, 1'b0);
    tick(2);
    rd_open = 1'b1; tick(1);

    // 5: G=0 R=3 N=1
    wb = wr_total; sb = stim_total;
    send_cmd(1, 0, 3);
    wait_eof("t5", 400, 0);
    tick(1);
    check("t5_writes", wr_total - wb, 3);
    check("t5_stim_cycles", stim_total - sb, 48);
    close_run();

    // 6: reset while in the gap
    send_cmd(3, 5, 2);
    k = 0;
    while (!(m_running && m_pulse_left == 0 && m_pos >= 3) && k < 500) begin
      tick(1); k++;
    end
    check("t6_reached_gap", k < 500, 1'b1);
    rst = 1'b1; tick(1); rst = 1'b0;
    #2;
    check("t6_busy", busy, 1'b0);
    check("t6_cap_data", cap_data, 16'h0);
    check("t6_stim", stim_pulse, 1'b0);
    wb = wr_total;
    send_cmd(2, 1, 1);
    wait_eof("t6_new", 400, 0);
    tick(1);
    check("t6_writes", wr_total - wb, 2);
    close_run();

    // Boundaries: N=4095 single rep, and R=255 single-sample reps
    gen_period = 1;
    wb = wr_total;
    send_cmd(4095, 0, 1);
    wait_eof("b_n4095", 5000, 0);
    tick(1);
    check("b_n4095_writes", wr_total - wb, 4095);
    close_run();
    wb = wr_total; sb = stim_total;
    send_cmd(1, 0, 255);
    wait_eof("b_r255", 6000, 0);
    tick(1);
    check("b_r255_writes", wr_total - wb, 255);
    check("b_r255_stim_cycles", stim_total - sb, 255 * STIM);
    close_run();

    // Randomized runs
    for (int i = 0; i < 14; i++) begin
      gen_mode = $urandom_range(1, 2);
      gen_period = $urandom_range(1, 5);
      full_mode = $urandom_range(0, 1);
      send_cmd($urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(1, 3));
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(5, 60));
        rd_open = 1'b0;
        tick(2);
        rd_open = 1'b1;
        tick(1);
      end else begin
        wait_eof("rand", 2000, 1);
        tick($urandom_range(0, 3));
        close_run();
      end
    end
    gen_mode = 0; full_mode = 0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
